// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode 7-seg scanner for the BCD time-of-day counter.
// Optional colon blink on the slot 2/4 decimal points: define SEG7_COLON_BLINK_EN.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_1s,
    input  logic [3:0] sec_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] min_10s,
    input  logic [3:0] hr_1s,
    input  logic [3:0] hr_10s,
    input  logic       blank_lead,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic          wrap;
    logic          frame_end;

    assign wrap      = (cnt == CNT_LAST);
    assign frame_end = wrap && (idx == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 3'd0;
        end else if (frame_end) begin
            idx <= 3'd0;
        end else if (wrap) begin
            idx <= idx + 3'd1;
        end
    end

    // One capture per frame keeps a frame from mixing old and new time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (frame_end) begin
            snap <= {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s};
        end
    end

    logic [3:0] digit;

    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = snap[3:0];
            3'd1:    digit = snap[7:4];
            3'd2:    digit = snap[11:8];
            3'd3:    digit = snap[15:12];
            3'd4:    digit = snap[19:16];
            3'd5:    digit = snap[23:20];
            default: digit = 4'd0;
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic       lit;
    logic       lead_off;
    logic [5:0] an_d;
    logic [6:0] seg_d;

    assign lit      = (cnt >= BLANK_END);
    assign lead_off = (idx == 3'd5) && blank_lead && (snap[23:20] == 4'd0);

    always_comb begin
        an_d  = 6'b111111;
        seg_d = 7'b1111111;
        if (lit && !lead_off) begin
            an_d  = ~(6'b000001 << idx);
            seg_d = seg_decode(digit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= 6'b111111;
            seg_n <= 7'b1111111;
        end else begin
            an_n  <= an_d;
            seg_n <= seg_d;
        end
    end

`ifdef SEG7_COLON_BLINK_EN
    // Even seconds light the points between hh:mm:ss -> 0.5 Hz blink.
    logic dp_d;

    assign dp_d = !(lit && ((idx == 3'd2) || (idx == 3'd4)) && !snap[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_n <= 1'b1;
        end else begin
            dp_n <= dp_d;
        end
    end
`else
    assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at REFRESH_DIV=8, BLANK_CYC=2.
// Expected outputs are queued by position p = slot*8 + cnt within the run.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;
    logic       blank_lead;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .sec_1s(sec_1s), .sec_10s(sec_10s),
        .min_1s(min_1s), .min_10s(min_10s),
        .hr_1s(hr_1s), .hr_10s(hr_10s),
        .blank_lead(blank_lead),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

`ifdef SEG7_COLON_BLINK_EN
    localparam bit COLON = 1'b1;
`else
    localparam bit COLON = 1'b0;
`endif

    localparam logic [5:0] OFF = 6'b111111;
    localparam logic [5:0] S0 = 6'b111110, S1 = 6'b111101, S2 = 6'b111011;
    localparam logic [5:0] S3 = 6'b110111, S4 = 6'b101111, S5 = 6'b011111;
    localparam logic [6:0] BL = 7'b1111111, DASH = 7'b0111111;
    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010, D7 = 7'b1111000, D9 = 7'b0010000;

    typedef struct {
        int         p;
        logic [5:0] an;
        logic [6:0] seg;
        bit         chk_seg;
        bit         colon;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [5:0] an_e,
                         input logic [6:0] seg_e, input bit chk_seg,
                         input logic dp_e);
        bit ok;
        ok = (an_n === an_e) && (!chk_seg || seg_n === seg_e) && (dp_n === dp_e);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got an_n=%b seg_n=%b dp_n=%b, expected an_n=%b seg_n=%b dp_n=%b",
                     name, an_n, seg_n, dp_n, an_e, seg_e, dp_e);
        end
    endtask

    task automatic push(input int p, input logic [5:0] an, input logic [6:0] seg,
                        input bit chk_seg, input bit colon, input string name);
        exp_t e;
        e.p = p; e.an = an; e.seg = seg;
        e.chk_seg = chk_seg; e.colon = colon; e.name = name;
        q.push_back(e);
    endtask

    // Monitor: output after edge k reflects state position p = k-1.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (q.size() != 0 && q[0].p <= cyc - 1) begin
                exp_t e;
                e = q.pop_front();
                if (e.p < cyc - 1) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: sample at p=%0d missed, now p=%0d", e.name, e.p, cyc - 1);
                end else begin
                    check(e.name, e.an, e.seg, e.chk_seg, (COLON && e.colon) ? 1'b0 : 1'b1);
                end
            end
        end
    end

    task automatic wait_p(input int t);
        int n;
        n = 0;
        while ((cyc - 1) < t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_p: position %0d not reached, at %0d", t, cyc - 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        blank_lead = 1'b0;
        {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s} = '0;
        repeat (3) @(negedge clk);
        check("reset_hold", OFF, BL, 1'b1, 1'b1);

        // 12:34:56 captured at the end of frame 0, shown in frame 1.
        {hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s} =
            {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

        push(0,   OFF, BL, 1, 0, "f0_s0_blank_c0");
        push(1,   OFF, BL, 1, 0, "f0_s0_blank_c1");
        push(2,   S0,  D0, 1, 0, "f0_s0_lit_c2");
        push(7,   S0,  D0, 1, 0, "f0_s0_lit_c7");
        push(8,   OFF, BL, 1, 0, "f0_s1_blank_c0");
        push(9,   OFF, BL, 1, 0, "f0_s1_blank_c1");
        push(10,  S1,  D0, 1, 0, "f0_s1_lit_c2");
        push(18,  S2,  D0, 1, 1, "f0_s2_zero_colon");
        push(42,  S5,  D0, 1, 0, "f0_s5_zero");
        push(50,  S0,  D6, 1, 0, "f1_s0_six");
        push(58,  S1,  D5, 1, 0, "f1_s1_five");
        push(64,  OFF, BL, 1, 0, "f1_s2_blank_dp");
        push(66,  S2,  D4, 1, 1, "f1_s2_four_colon");
        push(74,  S3,  D3, 1, 0, "f1_s3_three");
        push(82,  S4,  D2, 1, 1, "f1_s4_two_colon");
        push(90,  S5,  D1, 1, 0, "f1_s5_one");
        push(98,  S0,  D7, 1, 0, "f2_s0_seven");
        push(114, S2,  D4, 1, 0, "f2_s2_odd_sec_dp");
        push(130, S4,  D2, 1, 0, "f2_s4_odd_sec_dp");
        push(162, S2,  DASH, 1, 1, "f3_s2_dash");
        push(170, S3,  D3, 1, 0, "f3_s3_three");
        push(178, S4,  D9, 1, 1, "f3_s4_nine");
        push(186, OFF, BL, 0, 0, "f3_s5_lead_blank_c2");
        push(191, OFF, BL, 0, 0, "f3_s5_lead_blank_c7");
        push(234, S5,  D0, 1, 0, "f4_s5_lead_shown");

        #2 rst_n = 1'b1;
        #1 check("reset_release", OFF, BL, 1'b1, 1'b1);

        wait_p(68);
        sec_1s = 4'd7;
        wait_p(100);
        {hr_10s, hr_1s, min_1s, sec_1s} = {4'd0, 4'd9, 4'hC, 4'd4};
        wait_p(144);
        blank_lead = 1'b1;
        wait_p(192);
        blank_lead = 1'b0;
        wait_p(236);

        rst_n = 1'b0;
        #1 check("async_reset_mid_slot", OFF, BL, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        push(0,  OFF, BL, 1, 0, "rst2_s0_blank");
        push(2,  S0,  D0, 1, 0, "rst2_s0_zero");
        push(9,  OFF, BL, 1, 0, "rst2_s1_blank");
        push(10, S1,  D0, 1, 0, "rst2_s1_zero");
        #2 rst_n = 1'b1;
        wait_p(12);
        @(negedge clk);

        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: %0d expected samples never compared, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
